// File: rtl/cve2_irq_source.sv
// rtl/cve2_irq_source.sv - CLINT-style software/timer irq plus fast and external irq conditioning on a req/gnt/rvalid slave port
// Optional input synchronisers: define CVE2_IRQ_SOURCE_SYNC_EN
module cve2_irq_source #(
    parameter int unsigned TimerWidth = 64,
    parameter int unsigned NumFastIrq = 16,
    parameter int unsigned AddrWidth  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    input  logic                  tick_i,
    input  logic                  ext_irq_i,
    input  logic [NumFastIrq-1:0] fast_irq_i,
    output logic                  irq_software_o,
    output logic                  irq_timer_o,
    output logic                  irq_external_o,
    output logic [15:0]           irq_fast_o
);

    // Merge write data into a register value under a per-bit byte mask
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    logic                  msip_q, msip_d;
    logic [TimerWidth-1:0] mtime_q, mtime_d;
    logic [TimerWidth-1:0] mtimecmp_q, mtimecmp_d;
    logic [NumFastIrq-1:0] fast_en_q, fast_en_d;
    logic [NumFastIrq-1:0] fast_mode_q, fast_mode_d;
    logic [NumFastIrq-1:0] fast_pend_q, fast_pend_d;
    logic [NumFastIrq-1:0] fast_prev_q, fast_prev_d;
    logic [NumFastIrq-1:0] irq_fast_q, irq_fast_d;
    logic                  irq_timer_q, irq_timer_d;
    logic                  irq_external_q, irq_external_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0]           off;
    logic [2:0]            sel;
    logic                  acc_ok;
    logic [31:0]           be_mask;
    logic [63:0]           mtime_ext;
    logic [63:0]           mtimecmp_ext;
    logic [NumFastIrq-1:0] fast_w1c;
    logic [NumFastIrq-1:0] fast_edge;
    logic                  mtime_wr_hit;
    logic                  ext_src;
    logic [NumFastIrq-1:0] fast_src;
    logic                  unused_addr;

    // Address bits above AddrWidth are decoded by the interconnect
    assign unused_addr = ^addr_i[31:AddrWidth];
    assign off         = 32'(addr_i[AddrWidth-1:0]);
    assign sel         = off[4:2];
    assign acc_ok      = req_i && (off[1:0] == 2'b00) && (off < 32'h20);
    assign be_mask     = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign gnt_o       = req_i;

`ifdef CVE2_IRQ_SOURCE_SYNC_EN
    logic [1:0]            ext_sync_q, ext_sync_d;
    logic [NumFastIrq-1:0] fast_sync1_q, fast_sync1_d;
    logic [NumFastIrq-1:0] fast_sync2_q, fast_sync2_d;

    // Two-stage synchroniser next-state for the asynchronous irq inputs
    always_comb begin
        ext_sync_d   = {ext_sync_q[0], ext_irq_i};
        fast_sync1_d = fast_irq_i;
        fast_sync2_d = fast_sync1_q;
    end

    // Synchroniser flops, cleared so no spurious edge follows reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_sync_q   <= '0;
            fast_sync1_q <= '0;
            fast_sync2_q <= '0;
        end else begin
            ext_sync_q   <= ext_sync_d;
            fast_sync1_q <= fast_sync1_d;
            fast_sync2_q <= fast_sync2_d;
        end
    end

    assign ext_src  = ext_sync_q[1];
    assign fast_src = fast_sync2_q;
`else
    assign ext_src  = ext_irq_i;
    assign fast_src = fast_irq_i;
`endif

    assign fast_edge = fast_src & ~fast_prev_q;

    // Register file, timer, fast-irq pending logic and bus response next-state
    always_comb begin
        mtime_ext      = 64'(mtime_q);
        mtimecmp_ext   = 64'(mtimecmp_q);
        msip_d         = msip_q;
        mtime_d        = mtime_q;
        mtimecmp_d     = mtimecmp_q;
        fast_en_d      = fast_en_q;
        fast_mode_d    = fast_mode_q;
        fast_pend_d    = fast_pend_q;
        fast_prev_d    = fast_src;
        fast_w1c       = '0;
        mtime_wr_hit   = 1'b0;
        rvalid_d       = req_i;
        err_d          = req_i && !acc_ok;
        rdata_d        = '0;

        // Reads return the value held before any same-cycle update
        if (acc_ok && !we_i) begin
            case (sel)
                3'd0:    rdata_d = {31'b0, msip_q};
                3'd1:    rdata_d = 32'(fast_pend_q);
                3'd2:    rdata_d = 32'(fast_en_q);
                3'd3:    rdata_d = 32'(fast_mode_q);
                3'd4:    rdata_d = mtime_ext[31:0];
                3'd5:    rdata_d = mtime_ext[63:32];
                3'd6:    rdata_d = mtimecmp_ext[31:0];
                default: rdata_d = mtimecmp_ext[63:32];
            endcase
        end

        if (acc_ok && we_i) begin
            case (sel)
                3'd0: msip_d = be_i[0] ? wdata_i[0] : msip_q;
                3'd1: fast_w1c = NumFastIrq'(wdata_i & be_mask);
                3'd2: fast_en_d = NumFastIrq'(be_merge(32'(fast_en_q), wdata_i, be_mask));
                3'd3: fast_mode_d = NumFastIrq'(be_merge(32'(fast_mode_q), wdata_i, be_mask));
                3'd4: begin
                    mtime_d      = TimerWidth'({mtime_ext[63:32],
                                                be_merge(mtime_ext[31:0], wdata_i, be_mask)});
                    mtime_wr_hit = 1'b1;
                end
                3'd5: begin
                    mtime_d      = TimerWidth'({be_merge(mtime_ext[63:32], wdata_i, be_mask),
                                                mtime_ext[31:0]});
                    mtime_wr_hit = 1'b1;
                end
                3'd6: mtimecmp_d = TimerWidth'({mtimecmp_ext[63:32],
                                                be_merge(mtimecmp_ext[31:0], wdata_i, be_mask)});
                default: mtimecmp_d = TimerWidth'({be_merge(mtimecmp_ext[63:32], wdata_i, be_mask),
                                                   mtimecmp_ext[31:0]});
            endcase
        end

        // A software write to mtime takes priority over the tick
        if (!mtime_wr_hit && tick_i) begin
            mtime_d = mtime_q + TimerWidth'(1);
        end

        // Mode change flushes pending; edge set beats a same-cycle clear
        for (int unsigned i = 0; i < NumFastIrq; i++) begin
            if (fast_mode_d[i] != fast_mode_q[i]) begin
                fast_pend_d[i] = 1'b0;
            end else if (!fast_mode_q[i]) begin
                fast_pend_d[i] = fast_src[i];
            end else begin
                fast_pend_d[i] = fast_edge[i] | (fast_pend_q[i] & ~fast_w1c[i]);
            end
        end

        irq_fast_d     = fast_pend_d & fast_en_d;
        irq_timer_d    = (mtime_q >= mtimecmp_q);
        irq_external_d = ext_src;
    end

    // State and registered outputs; reset drops any in-flight response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msip_q         <= 1'b0;
            mtime_q        <= '0;
            mtimecmp_q     <= '1;
            fast_en_q      <= '0;
            fast_mode_q    <= '0;
            fast_pend_q    <= '0;
            fast_prev_q    <= '0;
            irq_fast_q     <= '0;
            irq_timer_q    <= 1'b0;
            irq_external_q <= 1'b0;
            rvalid_q       <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
        end else begin
            msip_q         <= msip_d;
            mtime_q        <= mtime_d;
            mtimecmp_q     <= mtimecmp_d;
            fast_en_q      <= fast_en_d;
            fast_mode_q    <= fast_mode_d;
            fast_pend_q    <= fast_pend_d;
            fast_prev_q    <= fast_prev_d;
            irq_fast_q     <= irq_fast_d;
            irq_timer_q    <= irq_timer_d;
            irq_external_q <= irq_external_d;
            rvalid_q       <= rvalid_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
        end
    end

    assign rvalid_o       = rvalid_q;
    assign err_o          = err_q;
    assign rdata_o        = rdata_q;
    assign irq_software_o = msip_q;
    assign irq_timer_o    = irq_timer_q;
    assign irq_external_o = irq_external_q;
    assign irq_fast_o     = 16'(irq_fast_q);

endmodule
